// File: rtl/quantser_ctrl.sv
// quantser_ctrl: sequencer for one quantser (quantizer/serializer) lane.
// Accepts a job (word count, MSB index, bits per word), pulls words over a
// valid/ready handshake, drives quantser clr/load/step/msbidx and presents
// the serial bit stream downstream with a per-word last flag.
// Optional build macro: QUANTSER_CTRL_PIPE_EN -- loads the next word on the
// last-bit handshake of the current one, removing the bubble between words.
module quantser_ctrl #(
    parameter int BWIN     = 32,
    parameter int BWMSBIDX = $clog2(BWIN),
    parameter int BWWCNT   = 16
) (
    input  logic                clk,
    input  logic                clr_n,
    input  logic                start,
    input  logic                abort,
    input  logic [BWMSBIDX-1:0] cfg_msbidx,
    input  logic [BWMSBIDX-1:0] cfg_nbitsm1,
    input  logic [BWWCNT-1:0]   cfg_nwords,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                qs_clr,
    output logic                qs_load,
    output logic                qs_step,
    output logic [BWMSBIDX-1:0] qs_msbidx,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_SERIAL = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [BWMSBIDX-1:0] msbidx_q, msbidx_d;
    logic [BWMSBIDX-1:0] nbitsm1_q, nbitsm1_d;
    logic [BWMSBIDX-1:0] bitcnt_q, bitcnt_d;
    logic [BWWCNT-1:0]   wordcnt_q, wordcnt_d;
    logic                done_q, done_d;

    // State and job registers; async reset returns everything to idle zeros.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= S_IDLE;
            msbidx_q  <= '0;
            nbitsm1_q <= '0;
            bitcnt_q  <= '0;
            wordcnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            msbidx_q  <= msbidx_d;
            nbitsm1_q <= nbitsm1_d;
            bitcnt_q  <= bitcnt_d;
            wordcnt_q <= wordcnt_d;
            done_q    <= done_d;
        end
    end

    // Next-state and quantser/handshake control; abort overrides every state.
    always_comb begin
        state_d   = state_q;
        msbidx_d  = msbidx_q;
        nbitsm1_d = nbitsm1_q;
        bitcnt_d  = bitcnt_q;
        wordcnt_d = wordcnt_q;
        done_d    = 1'b0;
        in_ready  = 1'b0;
        qs_clr    = 1'b0;
        qs_load   = 1'b0;
        qs_step   = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;

        if (abort) begin
            // Flush the quantser and drop all handshakes this cycle.
            qs_clr  = 1'b1;
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_nwords != '0) begin
                            msbidx_d  = cfg_msbidx;
                            nbitsm1_d = cfg_nbitsm1;
                            wordcnt_d = cfg_nwords;
                            qs_clr    = 1'b1;
                            state_d   = S_LOAD;
                        end else begin
                            // Empty job completes immediately.
                            done_d = 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        qs_load  = 1'b1;
                        bitcnt_d = nbitsm1_q;
                        state_d  = S_SERIAL;
                    end
                end
                S_SERIAL: begin
                    out_valid = 1'b1;
                    out_last  = (bitcnt_q == '0);
`ifdef QUANTSER_CTRL_PIPE_EN
                    in_ready  = out_last & out_ready & (wordcnt_q != BWWCNT'(1));
`endif
                    if (out_ready) begin
                        if (!out_last) begin
                            qs_step  = 1'b1;
                            bitcnt_d = bitcnt_q - 1'b1;
                        end else begin
                            // Last bit leaves: no step, the word is finished.
                            wordcnt_d = wordcnt_q - 1'b1;
                            if (wordcnt_q == BWWCNT'(1)) begin
                                done_d  = 1'b1;
                                state_d = S_IDLE;
                            end else begin
`ifdef QUANTSER_CTRL_PIPE_EN
                                if (in_valid) begin
                                    qs_load  = 1'b1;
                                    bitcnt_d = nbitsm1_q;
                                end else begin
                                    state_d = S_LOAD;
                                end
`else
                                state_d = S_LOAD;
`endif
                            end
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign qs_msbidx = msbidx_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_quantser_ctrl.sv
// Self-checking bench for quantser_ctrl with a behavioural quantser model
// and a job-level reference of the expected serial bit stream.
module tb_quantser_ctrl;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       start, abort;
    logic [4:0] cfg_msbidx, cfg_nbitsm1;
    logic [15:0] cfg_nwords;
    logic       in_valid, in_ready;
    logic       qs_clr, qs_load, qs_step;
    logic [4:0] qs_msbidx;
    logic       out_valid, out_ready, out_last, busy, done;

    logic [31:0] din;
    logic [31:0] sh;
    logic        qs_dout;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] words[$];
    bit          obs_bits[$];
    bit          obs_last[$];
    bit          exp_bits[$];
    bit          exp_last[$];
    int          obs_steps, obs_stall_err, obs_done_cnt, first_v, last_hs;
    bit          obs_timeout, obs_done_after, obs_busy_after, obs_clr_start;

    quantser_ctrl dut (
        .clk(clk), .clr_n(clr_n), .start(start), .abort(abort),
        .cfg_msbidx(cfg_msbidx), .cfg_nbitsm1(cfg_nbitsm1), .cfg_nwords(cfg_nwords),
        .in_valid(in_valid), .in_ready(in_ready),
        .qs_clr(qs_clr), .qs_load(qs_load), .qs_step(qs_step), .qs_msbidx(qs_msbidx),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Behavioural quantser: load a word, shift left on step, output bit at msbidx.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)       sh <= '0;
        else if (qs_clr)  sh <= '0;
        else if (qs_load) sh <= din;
        else if (qs_step) sh <= sh << 1;
    end
    assign qs_dout = sh[qs_msbidx];

    // Reference stream: word j, bit k is din[mi-k], or 0 once past bit 0.
    function automatic void build_expected(input int nw, input int nb, input int mi);
        logic [31:0] w;
        exp_bits.delete(); exp_last.delete();
        for (int j = 0; j < nw; j++) begin
            w = words[j];
            for (int k = 0; k <= nb; k++) begin
                exp_bits.push_back((mi >= k) ? w[mi-k] : 1'b0);
                exp_last.push_back(k == nb);
            end
        end
    endfunction

    // Runs one job on the words queue and records what the DUT produced.
    task automatic run_job(input int nw, input int nb, input int mi,
                           input int rdy_mode, input int vld_mode);
        int widx = 0, hs = 0, cyc = 0;
        int total = nw * (nb + 1);
        bit prev_stall = 0, prev_bit = 0;
        obs_bits.delete(); obs_last.delete();
        obs_steps = 0; obs_stall_err = 0; obs_done_cnt = 0; first_v = -1; last_hs = -1;
        @(negedge clk);
        cfg_nwords = 16'(nw); cfg_nbitsm1 = 5'(nb); cfg_msbidx = 5'(mi);
        start = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        #1 obs_clr_start = qs_clr;
        while (hs < total && cyc < 2000) begin
            @(negedge clk);
            start     = 1'b0;
            in_valid  = (vld_mode == 0) ? 1'b1 : 1'($urandom % 2);
            out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? (cyc % 2 == 0) : 1'($urandom % 2);
            din       = (widx < nw) ? words[widx] : 32'h0;
            #1;
            if (prev_stall && (!out_valid || qs_dout !== prev_bit)) obs_stall_err++;
            if (qs_load) widx++;
            if (qs_step) obs_steps++;
            if (done) obs_done_cnt++;
            if (out_valid && first_v < 0) first_v = cyc;
            if (out_valid && out_ready) begin
                obs_bits.push_back(qs_dout);
                obs_last.push_back(out_last);
                hs++;
                last_hs = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_bit   = qs_dout;
            cyc++;
        end
        obs_timeout = (hs < total);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        obs_done_after = done;
        obs_busy_after = busy;
        if (done) obs_done_cnt++;
        @(negedge clk);
        #1 if (done) obs_done_cnt++;
    endtask

    task automatic test_reset();
        clr_n = 1'b0; start = 0; abort = 0; in_valid = 0; out_ready = 0;
        cfg_msbidx = 0; cfg_nbitsm1 = 0; cfg_nwords = 0; din = 0;
        #3;
        n_chk++;
        if ({in_ready, qs_clr, qs_load, qs_step, qs_msbidx, out_valid, out_last, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required 0",
                     {in_ready, qs_clr, qs_load, qs_step, qs_msbidx, out_valid, out_last, busy, done});
        end
        @(negedge clk);
        clr_n = 1'b1;
    endtask

    task automatic test_basic();
        words.delete(); words.push_back(32'hA5);
        run_job(1, 3, 7, 0, 0);
        exp_bits = '{1'b1, 1'b0, 1'b1, 1'b0};
        exp_last = '{1'b0, 1'b0, 1'b0, 1'b1};
        n_chk++;
        if (obs_clr_start !== 1'b1) begin n_fail++; $display("FAIL basic_clr: got %0d required 1", obs_clr_start); end
        n_chk++;
        if (obs_timeout || obs_bits.size() != 4) begin
            n_fail++; $display("FAIL basic_count: got %0d bits required 4", obs_bits.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_chk++;
                if (obs_bits[i] !== exp_bits[i] || obs_last[i] !== exp_last[i]) begin
                    n_fail++;
                    $display("FAIL basic_bit%0d: got bit %0d last %0d required bit %0d last %0d",
                             i, obs_bits[i], obs_last[i], exp_bits[i], exp_last[i]);
                end
            end
        end
        n_chk++;
        if (obs_done_after !== 1'b1 || obs_done_cnt != 1 || obs_busy_after !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: got done %0d count %0d busy %0d required 1 1 0",
                     obs_done_after, obs_done_cnt, obs_busy_after);
        end
        n_chk++;
        if (obs_steps != 3) begin n_fail++; $display("FAIL basic_steps: got %0d required 3", obs_steps); end
    endtask

    task automatic test_stall();
        int nlast = 0;
        words.delete();
        for (int i = 0; i < 3; i++) words.push_back($urandom);
        run_job(3, 1, 20, 1, 0);
        build_expected(3, 1, 20);
        n_chk++;
        if (obs_timeout || obs_bits.size() != exp_bits.size()) begin
            n_fail++; $display("FAIL stall_count: got %0d bits required %0d", obs_bits.size(), exp_bits.size());
        end else begin
            for (int i = 0; i < exp_bits.size(); i++) begin
                n_chk++;
                if (obs_bits[i] !== exp_bits[i] || obs_last[i] !== exp_last[i]) begin
                    n_fail++;
                    $display("FAIL stall_bit%0d: got %0d/%0d required %0d/%0d",
                             i, obs_bits[i], obs_last[i], exp_bits[i], exp_last[i]);
                end
                if (obs_last[i]) nlast++;
            end
            n_chk++;
            if (nlast != 3) begin n_fail++; $display("FAIL stall_lasts: got %0d required 3", nlast); end
        end
        n_chk++;
        if (obs_stall_err != 0) begin n_fail++; $display("FAIL stall_hold: got %0d unstable cycles required 0", obs_stall_err); end
        n_chk++;
        if (obs_steps != 3) begin n_fail++; $display("FAIL stall_steps: got %0d required 3", obs_steps); end
        n_chk++;
        if (obs_done_cnt != 1) begin n_fail++; $display("FAIL stall_done: got %0d pulses required 1", obs_done_cnt); end
    endtask

    task automatic test_back_to_back();
        int span, exp_span;
        words.delete();
        for (int i = 0; i < 4; i++) words.push_back($urandom);
        run_job(4, 0, 31, 0, 0);
        build_expected(4, 0, 31);
`ifdef QUANTSER_CTRL_PIPE_EN
        exp_span = 4;
`else
        exp_span = 7;
`endif
        span = last_hs - first_v + 1;
        n_chk++;
        if (obs_timeout || span != exp_span) begin
            n_fail++; $display("FAIL b2b_span: got %0d cycles required %0d", span, exp_span);
        end
        n_chk++;
        if (obs_bits.size() != 4 || obs_bits != exp_bits) begin
            n_fail++; $display("FAIL b2b_bits: got %0d bits required 4 matching bits", obs_bits.size());
        end
        n_chk++;
        if (obs_done_cnt != 1) begin n_fail++; $display("FAIL b2b_done: got %0d required 1", obs_done_cnt); end
    endtask

    task automatic test_random();
        int nw, nb, mi, bad;
        for (int t = 0; t < 8; t++) begin
            nw = $urandom_range(1, 5);
            nb = $urandom_range(0, 12);
            mi = (t == 0) ? 2 : $urandom_range(0, 31);
            if (t == 0) nb = 6;
            words.delete();
            for (int i = 0; i < nw; i++) words.push_back($urandom);
            run_job(nw, nb, mi, 2, 1);
            build_expected(nw, nb, mi);
            bad = 0;
            for (int i = 0; i < obs_bits.size() && i < exp_bits.size(); i++)
                if (obs_bits[i] !== exp_bits[i] || obs_last[i] !== exp_last[i]) bad++;
            n_chk++;
            if (obs_timeout || obs_bits.size() != exp_bits.size() || bad != 0) begin
                n_fail++;
                $display("FAIL rand%0d_stream: got %0d bits %0d wrong required %0d bits 0 wrong",
                         t, obs_bits.size(), bad, exp_bits.size());
            end
            n_chk++;
            if (obs_steps != nw * nb || obs_stall_err != 0) begin
                n_fail++;
                $display("FAIL rand%0d_steps: got %0d steps %0d unstable required %0d steps 0 unstable",
                         t, obs_steps, obs_stall_err, nw * nb);
            end
            n_chk++;
            if (obs_done_cnt != 1 || obs_done_after !== 1'b1) begin
                n_fail++; $display("FAIL rand%0d_done: got %0d pulses required 1", t, obs_done_cnt);
            end
        end
    endtask

    task automatic test_abort();
        int dcnt = 0;
        words.delete(); words.push_back($urandom);
        @(negedge clk);
        cfg_nwords = 16'd3; cfg_nbitsm1 = 5'd7; cfg_msbidx = 5'd31; start = 1'b1;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; din = words[0]; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        #1;
        n_chk++;
        if ({qs_clr, out_valid, in_ready, qs_load, qs_step} !== 5'b10000) begin
            n_fail++; $display("FAIL abort_cycle: got clr/ov/ir/ld/st %b required 10000",
                               {qs_clr, out_valid, in_ready, qs_load, qs_step});
        end
        @(negedge clk);
        abort = 1'b0;
        #1;
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %0d required 0", busy); end
        for (int i = 0; i < 5; i++) begin
            if (done) dcnt++;
            @(negedge clk); #1;
        end
        n_chk++;
        if (dcnt != 0) begin n_fail++; $display("FAIL abort_done: got %0d pulses required 0", dcnt); end
        // abort and start together: abort wins
        @(negedge clk);
        start = 1'b1; abort = 1'b1; cfg_nwords = 16'd2;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        #1;
        n_chk++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL abort_vs_start: got busy %0d done %0d required 0 0", busy, done);
        end
    endtask

    task automatic test_zero_words();
        @(negedge clk);
        cfg_nwords = 16'd0; start = 1'b1;
        #1;
        n_chk++;
        if (in_ready !== 1'b0 || qs_clr !== 1'b0) begin
            n_fail++; $display("FAIL zero_start: got ir %0d clr %0d required 0 0", in_ready, qs_clr);
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        n_chk++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL zero_done: got done %0d busy %0d required 1 0", done, busy);
        end
        @(negedge clk); #1;
        n_chk++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL zero_pulse: got %0d required 0", done); end
        // start while busy is ignored
        @(negedge clk);
        cfg_nwords = 16'd1; cfg_nbitsm1 = 5'd3; cfg_msbidx = 5'd10; start = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        cfg_nwords = 16'd7; cfg_msbidx = 5'd20;
        #1;
        n_chk++;
        if (qs_clr !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL busy_start: got clr %0d busy %0d ir %0d required 0 1 1", qs_clr, busy, in_ready);
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        n_chk++;
        if (qs_msbidx !== 5'd10) begin n_fail++; $display("FAIL busy_msbidx: got %0d required 10", qs_msbidx); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        cfg_nwords = 16'd2; cfg_nbitsm1 = 5'd7; cfg_msbidx = 5'd31; start = 1'b1;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; din = $urandom;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        n_chk++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre: got out_valid %0d required 1", out_valid); end
        #2 clr_n = 1'b0;
        #1;
        n_chk++;
        if ({in_ready, qs_clr, qs_load, qs_step, qs_msbidx, out_valid, out_last, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL rst_async: got %b required 0",
                     {in_ready, qs_clr, qs_load, qs_step, qs_msbidx, out_valid, out_last, busy, done});
        end
        @(negedge clk);
        clr_n = 1'b1;
        words.delete();
        for (int i = 0; i < 2; i++) words.push_back($urandom);
        run_job(2, 4, 9, 0, 0);
        build_expected(2, 4, 9);
        n_chk++;
        if (obs_timeout || obs_bits != exp_bits || obs_last != exp_last || obs_done_cnt != 1) begin
            n_fail++; $display("FAIL rst_restart: got %0d bits %0d done required %0d bits 1 done",
                               obs_bits.size(), obs_done_cnt, exp_bits.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_abort();
        test_zero_words();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
